// File: rtl/scarf_spi_master.sv
// SCARF SPI initiator: mode-0 master that frames a {rnw, slave_id} header plus
// caller-supplied payload bytes, returning each received payload byte on a strobe.
module scarf_spi_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n_sync,
    input  logic       start,
    input  logic [6:0] slave_id,
    input  logic       rnw,
    input  logic [7:0] num_bytes,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);

    localparam int CW = 16;
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] DIV_PRE    = CW'(CLK_DIV - 2);
    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic        sclk_r, sclk_s;
    logic        ss_n_r, ss_n_s;
    logic        mosi_r, mosi_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic        wr_ready_r, wr_ready_s;
    logic        rd_valid_r, rd_valid_s;
    logic [7:0]  rd_data_r, rd_data_s;
    // tx_sh holds the bits still to go after the one currently on mosi
    logic [6:0]  tx_sh_r, tx_sh_s;
    logic [6:0]  rx_sh_r, rx_sh_s;
    logic [2:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]  bytes_left_r, bytes_left_s;
    logic        hdr_r, hdr_s;

    assign sclk     = sclk_r;
    assign ss_n     = ss_n_r;
    assign mosi     = mosi_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign wr_ready = wr_ready_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;

    // Next-state and next-register computation for the whole frame sequencer
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        sclk_s       = sclk_r;
        ss_n_s       = ss_n_r;
        mosi_s       = mosi_r;
        busy_s       = busy_r;
        done_s       = 1'b0;
        wr_ready_s   = 1'b0;
        rd_valid_s   = 1'b0;
        rd_data_s    = rd_data_r;
        tx_sh_s      = tx_sh_r;
        rx_sh_s      = rx_sh_r;
        bit_cnt_s    = bit_cnt_r;
        bytes_left_s = bytes_left_r;
        hdr_s        = hdr_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    busy_s       = 1'b1;
                    ss_n_s       = 1'b0;
                    sclk_s       = 1'b0;
                    mosi_s       = rnw;
                    tx_sh_s      = slave_id;
                    bytes_left_s = num_bytes;
                    bit_cnt_s    = 3'd0;
                    hdr_s        = 1'b1;
                    cnt_s        = CNT_ZERO;
                    state_s      = ST_SETUP;
                end else begin
                    busy_s = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_r == SETUP_LAST) begin
                    cnt_s   = CNT_ZERO;
                    state_s = ST_SHIFT;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_SHIFT: begin
                if (cnt_r == DIV_LAST) begin
                    cnt_s = CNT_ZERO;
                    if (!sclk_r) begin
                        sclk_s  = 1'b1;
                        rx_sh_s = {rx_sh_r[5:0], miso};
                        if ((bit_cnt_r == 3'd7) && !hdr_r) begin
                            rd_valid_s = 1'b1;
                            rd_data_s  = {rx_sh_r, miso};
                        end else begin
                            rd_valid_s = 1'b0;
                        end
                    end else begin
                        sclk_s = 1'b0;
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_s = 3'd0;
                            if (bytes_left_r == 8'd0) begin
                                mosi_s  = 1'b0;
                                state_s = ST_HOLD;
                            end else begin
                                tx_sh_s      = wr_data[6:0];
                                mosi_s       = wr_data[7];
                                bytes_left_s = bytes_left_r - 8'd1;
                                hdr_s        = 1'b0;
                            end
                        end else begin
                            bit_cnt_s = bit_cnt_r + 3'd1;
                            mosi_s    = tx_sh_r[6];
                            tx_sh_s   = {tx_sh_r[5:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                    // Raised one cycle early so the pulse coincides with the capture cycle
                    if (sclk_r && (cnt_r == DIV_PRE) && (bit_cnt_r == 3'd7)
                        && (bytes_left_r != 8'd0)) begin
                        wr_ready_s = 1'b1;
                    end else begin
                        wr_ready_s = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_r == HOLD_LAST) begin
                    cnt_s   = CNT_ZERO;
                    ss_n_s  = 1'b1;
                    mosi_s  = 1'b0;
                    done_s  = 1'b1;
                    state_s = ST_DONE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                busy_s  = 1'b0;
                ss_n_s  = 1'b1;
                sclk_s  = 1'b0;
                mosi_s  = 1'b0;
                cnt_s   = CNT_ZERO;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            cnt_r        <= CNT_ZERO;
            sclk_r       <= 1'b0;
            ss_n_r       <= 1'b1;
            mosi_r       <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            wr_ready_r   <= 1'b0;
            rd_valid_r   <= 1'b0;
            rd_data_r    <= 8'h00;
            tx_sh_r      <= 7'h00;
            rx_sh_r      <= 7'h00;
            bit_cnt_r    <= 3'd0;
            bytes_left_r <= 8'd0;
            hdr_r        <= 1'b0;
        end else begin
            cnt_r        <= cnt_s;
            sclk_r       <= sclk_s;
            ss_n_r       <= ss_n_s;
            mosi_r       <= mosi_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            wr_ready_r   <= wr_ready_s;
            rd_valid_r   <= rd_valid_s;
            rd_data_r    <= rd_data_s;
            tx_sh_r      <= tx_sh_s;
            rx_sh_r      <= rx_sh_s;
            bit_cnt_r    <= bit_cnt_s;
            bytes_left_r <= bytes_left_s;
            hdr_r        <= hdr_s;
        end
    end

endmodule

// File: doc/scarf_spi_master.md
Name: scarf_spi_master

Overview:
- SPI initiator that issues SCARF-framed transactions from the FPGA fabric to a downstream SCARF slave, such as a second board or a daisy-chained FPGA.
- It is the other end of the SCARF SPI slave. It generates sclk, ss_n and mosi, and samples miso.
- Frame = header byte {rnw, slave_id[6:0]} followed by caller-supplied payload bytes. Each payload byte clocked in on miso is returned on a byte strobe.
- Sits beside the existing SCARF slaves, driven by a local controller (pattern generator, or a future sequencer).

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period; must be >= 2.
- CS_SETUP, 2, clk cycles from ss_n fall to first sclk rise-half start; must be >= 1.
- CS_HOLD, 2, clk cycles from last sclk fall to ss_n rise; must be >= 1.

Ports:
- clk  input  1  fabric clock
- rst_n_sync  input  1  reset; asynchronous assert, active-low
- start  input  1  single-cycle request; accepted only when busy=0
- slave_id  input  7  target slave id; latched on accepted start
- rnw  input  1  1=read, 0=write; latched on accepted start
- num_bytes  input  8  payload byte count after header (0..255); latched on accepted start
- wr_data  input  8  next payload byte to transmit
- wr_ready  output  1  1-cycle pulse: wr_data captured into shifter this cycle
- rd_data  output  8  last payload byte received on miso
- rd_valid  output  1  1-cycle pulse: rd_data updated
- busy  output  1  high from accepted start through the done cycle
- done  output  1  1-cycle pulse at end of transaction
- sclk  output  1  SPI clock, mode 0 (idle low)
- ss_n  output  1  SPI chip select, active low
- mosi  output  1  SPI data out, MSB first
- miso  input  1  SPI data in

Behaviour:
- Reset values (asynchronous):
  - sclk=0, ss_n=1, mosi=0, busy=0, done=0, wr_ready=0, rd_valid=0, rd_data=8'h00.
  - State machine returns to IDLE.
- States: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - start=1 latches slave_id, rnw and num_bytes.
  - Next cycle: busy=1, ss_n=0, shifter loaded with {rnw, slave_id}, mosi=shifter[7]. Go to SETUP.
  - start while busy=1 is ignored; no queueing.
- SETUP:
  - Counts CS_SETUP cycles with sclk=0, then goes to SHIFT.
- SHIFT:
  - Each bit = CLK_DIV cycles of sclk low, then CLK_DIV cycles of sclk high.
  - miso is sampled into the receive shifter on the clk edge where sclk goes 0->1.
  - On the edge where sclk goes 1->0, the shifter advances and mosi updates. Data is therefore stable a full half-period before each rising sclk.
  - After bit 0 of a byte, the next byte loads on that same falling-edge cycle; there is no inter-byte gap. A payload load captures wr_data and pulses wr_ready in that cycle.
  - First payload byte: wr_data must be valid by the end of the header's final bit.
  - Later bytes: the caller has 16*CLK_DIV cycles after each wr_ready to present the next byte.
  - Read transactions transmit wr_data exactly as writes do. The caller supplies address bytes, then filler (8'h00).
- rd_valid / rd_data:
  - rd_valid pulses, with rd_data updated, in the cycle after bit 0 of each payload byte is sampled.
  - The header byte's received data is discarded (no rd_valid).
  - rd_valid fires for every payload byte regardless of rnw.
- End of shifting:
  - After the last byte's final sclk fall, go to HOLD; sclk stays 0.
  - num_bytes=0 sends the header only.
- HOLD:
  - Counts CS_HOLD cycles, then ss_n=1, mosi=0, go to DONE.
- DONE:
  - done=1 for one cycle; busy drops the cycle after.
  - start is accepted again on the cycle after DONE.
- Timing:
  - ss_n low duration = CS_SETUP + (num_bytes+1)*16*CLK_DIV + CS_HOLD clk cycles.
  - Exactly 8*(num_bytes+1) sclk rising edges per transaction.
- Inputs held stable: wr_data is sampled only at load points. Changes to slave_id, rnw or num_bytes during busy have no effect.
- Reset mid-transaction: all outputs return to reset values immediately. No done or rd_valid pulse is emitted.

Test Plan:
- Write, CLK_DIV=2, CS_SETUP=2, CS_HOLD=2: slave_id=7'h04, rnw=0, num_bytes=2, wr_data 8'h00 then 8'hA5.
  - mosi bitstream 8'h04, 8'h00, 8'hA5 MSB-first.
  - ss_n low exactly 100 cycles; 24 sclk rises; 2 wr_ready pulses; done once.
- Read loopback: miso tied to a SCARF slave model returning 8'h3C, 8'hC3; rnw=1, slave_id=7'h03, num_bytes=3, wr_data 8'h10 then 8'h00, 8'h00.
  - Header mosi = 8'h83.
  - rd_valid pulses 3 times; rd_data sequence = model's byte for the address phase, then 8'h3C, then 8'hC3.
- num_bytes=0 -> header only; 8 sclk rises; no wr_ready, no rd_valid; ss_n low CS_SETUP+16*CLK_DIV+CS_HOLD cycles.
- start pulsed again mid-transaction -> ignored; single done; bit count unchanged.
- rst_n_sync asserted during byte 2 of a 4-byte write -> ss_n=1, sclk=0, busy=0 asynchronously. No done. A fresh start after release completes a normal frame.
- Mode-0 timing check, CLK_DIV=4: mosi stable >= 4 cycles before every sclk rise; never changes while sclk=1; sclk=0 whenever ss_n=1.
